ap_txn_profiler: RTL and testbench



---
 rtl/ap_prof_pkg.sv | 17 +
 rtl/ts_fifo.sv | 54 +++++
 rtl/ap_txn_profiler.sv | 183 ++++++++++++++++++
 tb/tb_ap_txn_profiler.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ap_prof_pkg.sv
// Shared types and constants for the ap_ctrl transaction profiler.
// Record layout depends on the CNT_W/ID_W parameters of the top, so the record struct lives there.
package ap_prof_pkg;

    // Bit positions inside the sticky err_flags vector.
    localparam int ERR_UNDERFLOW = 0;
    localparam int ERR_OVERFLOW  = 1;
    localparam int ERR_DROP      = 2;
    localparam int ERR_W         = 3;

    // Start-side handshake tracker: ARMED means ap_start seen, ap_ready not yet.
    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } start_state_t;

endpackage

// File: rtl/ts_fifo.sv
// Start-timestamp FIFO: DEPTH entries of {start, interval}, with same-cycle push/pop.
// The caller may request push when full; it only lands if a pop frees a slot in that cycle.
module ts_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [W-1:0]           wdata,
    input  logic                   pop,
    output logic [W-1:0]           rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: the storage array has no reset; an entry is only read after count says it was written.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ap_txn_profiler.sv
// Converts each ap_start/ap_ready -> ap_done/ap_continue transaction of one HLS kernel
// into a timestamped {id, start, latency, interval} record on a valid/ready stream.
module ap_txn_profiler
    import ap_prof_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int DEPTH = 4,
    parameter int ID_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   ap_start,
    input  logic                   ap_ready,
    input  logic                   ap_done,
    input  logic                   ap_continue,
    input  logic                   finish,
    output logic                   rec_valid,
    input  logic                   rec_ready,
    output logic [ID_W-1:0]        rec_id,
    output logic [CNT_W-1:0]       rec_start,
    output logic [CNT_W-1:0]       rec_latency,
    output logic [CNT_W-1:0]       rec_interval,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic [ERR_W-1:0]       err_flags,
    output logic                   flush_done
);

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [CNT_W-1:0] start;
        logic [CNT_W-1:0] latency;
        logic [CNT_W-1:0] interval;
    } rec_t;

    start_state_t     state, state_next;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] start_ts;
    logic [CNT_W-1:0] prev_ts;
    logic             have_prev;
    logic             finish_seen;
    logic             flushed;
    logic [ID_W-1:0]  next_id;
    rec_t             rec_q;
    logic [ERR_W-1:0] err_q;

    logic             latch_ts;
    logic             push_req;
    logic [CNT_W-1:0] push_ts;
    logic [CNT_W-1:0] push_ival;
    logic             accept;
    logic             pop_req;
    logic             bypass;
    logic             fifo_push;
    logic             fifo_pop;
    logic             push_taken;
    logic             rec_fire;
    logic             underflow;
    logic             overflow;
    logic             flush_cond;
    logic [CNT_W-1:0] src_start;
    logic [CNT_W-1:0] src_ival;
    logic [2*CNT_W-1:0] fifo_rdata;
    logic             fifo_full;
    logic             fifo_empty;

    assign accept = !(finish || finish_seen);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        latch_ts   = 1'b0;
        push_req   = 1'b0;
        push_ts    = start_ts;
        case (state)
            IDLE: begin
                if (ap_start && accept) begin
                    if (ap_ready) begin
                        push_req = 1'b1;
                        push_ts  = cyc_cnt;
                    end else begin
                        latch_ts   = 1'b1;
                        state_next = ARMED;
                    end
                end
            end
            ARMED: begin
                if (ap_ready) begin
                    push_req   = 1'b1;
                    state_next = IDLE;
                end else if (!ap_start) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign push_ival = have_prev ? (push_ts - prev_ts) : '0;
    assign pop_req   = ap_done && ap_continue;

    // An empty FIFO with a same-cycle push hands the pushed entry straight to the record.
    assign bypass     = pop_req && push_req && fifo_empty;
    assign fifo_push  = push_req && !bypass && (!fifo_full || pop_req);
    assign fifo_pop   = pop_req && !fifo_empty;
    assign push_taken = fifo_push || bypass;
    assign rec_fire   = fifo_pop || bypass;
    assign underflow  = pop_req && fifo_empty && !push_req;
    assign overflow   = push_req && fifo_full && !pop_req;
    assign flush_cond = !accept && !flushed && fifo_empty && !rec_valid && !push_req;

    assign src_start = fifo_empty ? push_ts   : fifo_rdata[2*CNT_W-1:CNT_W];
    assign src_ival  = fifo_empty ? push_ival : fifo_rdata[CNT_W-1:0];

    ts_fifo #(
        .DEPTH (DEPTH),
        .W     (2 * CNT_W)
    ) u_ts_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({push_ts, push_ival}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (outstanding)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cyc_cnt     <= '0;
            start_ts    <= '0;
            prev_ts     <= '0;
            have_prev   <= 1'b0;
            finish_seen <= 1'b0;
            flushed     <= 1'b0;
            flush_done  <= 1'b0;
            err_q       <= '0;
        end else begin
            state   <= state_next;
            cyc_cnt <= cyc_cnt + CNT_W'(1);
            if (latch_ts) start_ts <= cyc_cnt;
            if (push_taken) begin
                prev_ts   <= push_ts;
                have_prev <= 1'b1;
            end
            if (finish) finish_seen <= 1'b1;
            flush_done <= flush_cond;
            if (flush_cond) flushed <= 1'b1;
            if (underflow) err_q[ERR_UNDERFLOW] <= 1'b1;
            if (overflow)  err_q[ERR_OVERFLOW]  <= 1'b1;
            if (rec_fire && rec_valid && !rec_ready) err_q[ERR_DROP] <= 1'b1;
        end
    end

    // Single-entry output register; a completion that finds it occupied is dropped but still numbered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rec_valid <= 1'b0;
            rec_q     <= '0;
            next_id   <= '0;
        end else if (rec_fire) begin
            next_id <= next_id + ID_W'(1);
            if (!rec_valid || rec_ready) begin
                rec_valid      <= 1'b1;
                rec_q.id       <= next_id;
                rec_q.start    <= src_start;
                rec_q.latency  <= cyc_cnt - src_start + CNT_W'(1);
                rec_q.interval <= src_ival;
            end
        end else if (rec_ready) begin
            rec_valid <= 1'b0;
        end
    end

    assign rec_id       = rec_q.id;
    assign rec_start    = rec_q.start;
    assign rec_latency  = rec_q.latency;
    assign rec_interval = rec_q.interval;
    assign err_flags    = err_q;

endmodule

// File: tb/tb_ap_txn_profiler.sv
// Directed bench for ap_txn_profiler: a queue-based transaction model checked every cycle
// against a 32-bit-counter instance and an 8-bit-counter instance driven in lockstep.
module tb_ap_txn_profiler;

    localparam int DEPTH = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1;
    logic finish = 1'b0, rec_ready = 1'b0;

    logic        rec_valid, flush_done;
    logic [15:0] rec_id;
    logic [31:0] rec_start, rec_latency, rec_interval;
    logic [2:0]  outstanding, err_flags;

    logic        rec_valid8, flush_done8;
    logic [15:0] rec_id8;
    logic [7:0]  rec_start8, rec_latency8, rec_interval8;
    logic [2:0]  outstanding8, err_flags8;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    ap_txn_profiler #(.CNT_W(32), .DEPTH(DEPTH), .ID_W(16)) dut (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_id(rec_id),
        .rec_start(rec_start), .rec_latency(rec_latency), .rec_interval(rec_interval),
        .outstanding(outstanding), .err_flags(err_flags), .flush_done(flush_done)
    );

    ap_txn_profiler #(.CNT_W(8), .DEPTH(DEPTH), .ID_W(16)) dut8 (
        .clock(clock), .reset(reset), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_done(ap_done), .ap_continue(ap_continue), .finish(finish),
        .rec_valid(rec_valid8), .rec_ready(rec_ready), .rec_id(rec_id8),
        .rec_start(rec_start8), .rec_latency(rec_latency8), .rec_interval(rec_interval8),
        .outstanding(outstanding8), .err_flags(err_flags8), .flush_done(flush_done8)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int unsigned m_cyc = 0;
    bit          m_armed = 0;
    int unsigned m_armed_ts = 0;
    int unsigned q_start[$];
    int unsigned q_int[$];
    bit          m_have_prev = 0;
    int unsigned m_prev = 0;
    int unsigned m_id = 0;
    bit          m_rv = 0;
    int unsigned m_rid = 0, m_rstart = 0, m_rlat = 0, m_rint = 0;
    bit [2:0]    m_err = 0;
    bit          m_fin = 0, m_flushed = 0, m_flush_done = 0;

    task automatic m_reset();
        m_cyc = 0; m_armed = 0; m_armed_ts = 0;
        q_start.delete(); q_int.delete();
        m_have_prev = 0; m_prev = 0; m_id = 0;
        m_rv = 0; m_rid = 0; m_rstart = 0; m_rlat = 0; m_rint = 0;
        m_err = 0; m_fin = 0; m_flushed = 0; m_flush_done = 0;
    endtask

    task automatic m_step();
        bit          acc, push, pop, got, consumed, taken, fcond;
        int unsigned pts, ival, rs, ri;
        if (reset) begin
            m_reset();
            return;
        end
        acc = !(finish || m_fin);
        push = 0; pts = 0; got = 0; consumed = 0; taken = 0; rs = 0; ri = 0;
        pop = ap_done && ap_continue;
        if (!m_armed) begin
            if (ap_start && acc) begin
                if (ap_ready) begin push = 1; pts = m_cyc; end
                else begin m_armed = 1; m_armed_ts = m_cyc; end
            end
        end else if (ap_ready) begin
            push = 1; pts = m_armed_ts; m_armed = 0;
        end else if (!ap_start) begin
            m_armed = 0;
        end
        fcond = !acc && !m_flushed && q_start.size() == 0 && !m_rv && !push;
        ival = m_have_prev ? pts - m_prev : 0;
        if (pop) begin
            if (q_start.size() > 0) begin
                rs = q_start.pop_front(); ri = q_int.pop_front(); got = 1;
            end else if (push) begin
                rs = pts; ri = ival; got = 1; consumed = 1; taken = 1;
            end else begin
                m_err[0] = 1;
            end
        end
        if (push && !consumed) begin
            if (q_start.size() < DEPTH) begin
                q_start.push_back(pts); q_int.push_back(ival); taken = 1;
            end else begin
                m_err[1] = 1;
            end
        end
        if (taken) begin m_prev = pts; m_have_prev = 1; end
        if (got) begin
            if (m_rv && !rec_ready) m_err[2] = 1;
            else begin
                m_rv = 1; m_rid = m_id & 16'hFFFF; m_rstart = rs;
                m_rlat = m_cyc - rs + 1; m_rint = ri;
            end
            m_id++;
        end else if (rec_ready) begin
            m_rv = 0;
        end
        m_flush_done = fcond;
        if (fcond) m_flushed = 1;
        if (finish) m_fin = 1;
        m_cyc++;
    endtask

    // Compare both instances against the model after every edge.
    always begin
        @(posedge clock);
        m_step();
        #1;
        check("rec_valid", rec_valid, m_rv);
        check("rec_valid8", rec_valid8, m_rv);
        check("outstanding", outstanding, q_start.size());
        check("outstanding8", outstanding8, q_start.size());
        check("err_flags", err_flags, m_err);
        check("err_flags8", err_flags8, m_err);
        check("flush_done", flush_done, m_flush_done);
        check("flush_done8", flush_done8, m_flush_done);
        if (m_rv) begin
            check("rec_id", rec_id, m_rid);
            check("rec_start", rec_start, m_rstart);
            check("rec_latency", rec_latency, m_rlat);
            check("rec_interval", rec_interval, m_rint);
            check("rec_id8", rec_id8, m_rid);
            check("rec_start8", rec_start8, m_rstart & 32'hFF);
            check("rec_latency8", rec_latency8, m_rlat & 32'hFF);
            check("rec_interval8", rec_interval8, m_rint & 32'hFF);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        ap_start = 0; ap_ready = 0; ap_done = 0; finish = 0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1; idle_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 0;
    endtask

    // Wait until the next rising edge will sample cyc_cnt == c.
    task automatic until_cyc(input int unsigned c);
        int guard = 0;
        while (m_cyc != c && guard < 2000) begin
            @(negedge clock);
            guard++;
        end
        check("until_cyc_reached", m_cyc, c);
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_valid"}, rec_valid, 0);
        check({tag, "_id"}, rec_id, 0);
        check({tag, "_start"}, rec_start, 0);
        check({tag, "_latency"}, rec_latency, 0);
        check({tag, "_interval"}, rec_interval, 0);
        check({tag, "_outstanding"}, outstanding, 0);
        check({tag, "_err"}, err_flags, 0);
        check({tag, "_flush"}, flush_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values.
        step(2);
        check_reset_vals("rst");

        // Single ap_ctrl_hs transaction: ready at 10, done at 25.
        do_reset();
        rec_ready = 0;
        until_cyc(10);
        ap_start = 1; ap_ready = 1;
        step(1);
        ap_start = 0; ap_ready = 0;
        until_cyc(25);
        ap_done = 1;
        step(1);
        ap_done = 0;
        check("single_valid", rec_valid, 1);
        check("single_id", rec_id, 0);
        check("single_start", rec_start, 10);
        check("single_latency", rec_latency, 16);
        check("single_interval", rec_interval, 0);
        rec_ready = 1;
        step(2);

        // Pipelined kernel: readies 5,7,9; dones 20,22,24.
        do_reset();
        rec_ready = 1;
        for (int c = 0; c <= 27; c++) begin
            ap_start = (c == 5 || c == 7 || c == 9);
            ap_ready = ap_start;
            ap_done  = (c == 20 || c == 22 || c == 24);
            if (c == 15) check("pipe_outstanding_peak", outstanding, 3);
            if (c == 23) begin
                check("pipe_id1", rec_id, 1);
                check("pipe_latency1", rec_latency, 16);
                check("pipe_interval1", rec_interval, 2);
            end
            if (c == 25) check("pipe_latency2", rec_latency, 16);
            step(1);
        end
        idle_inputs();

        // Counter wrap on the 8-bit instance: start 250, done 260 (= 4).
        do_reset();
        rec_ready = 0;
        until_cyc(250);
        ap_start = 1; ap_ready = 1;
        step(1);
        ap_start = 0; ap_ready = 0;
        until_cyc(260);
        ap_done = 1;
        step(1);
        ap_done = 0;
        check("wrap_start8", rec_start8, 250);
        check("wrap_latency8", rec_latency8, 11);
        check("wrap_latency32", rec_latency, 11);
        check("wrap_err8", err_flags8, 0);
        rec_ready = 1;
        step(2);

        // Overflow then underflow.
        do_reset();
        rec_ready = 1;
        until_cyc(2);
        ap_start = 1; ap_ready = 1;
        step(5);
        ap_start = 0; ap_ready = 0;
        check("ovf_outstanding", outstanding, 4);
        check("ovf_err", err_flags, 3'b010);
        ap_done = 1;
        step(5);
        ap_done = 0;
        check("udf_err", err_flags, 3'b011);
        check("udf_outstanding", outstanding, 0);
        step(2);

        // Backpressure: second record dropped, next accepted record is id 2.
        do_reset();
        rec_ready = 0;
        until_cyc(2);
        ap_start = 1; ap_ready = 1;
        step(2);
        ap_start = 0; ap_ready = 0;
        until_cyc(5);
        ap_done = 1;
        step(2);
        ap_done = 0;
        check("bp_held_id", rec_id, 0);
        check("bp_held_start", rec_start, 2);
        check("bp_held_latency", rec_latency, 4);
        check("bp_err", err_flags, 3'b100);
        rec_ready = 1;
        until_cyc(10);
        ap_start = 1; ap_ready = 1;
        step(1);
        ap_start = 0; ap_ready = 0;
        until_cyc(12);
        ap_done = 1;
        step(1);
        ap_done = 0;
        check("bp_next_id", rec_id, 2);
        check("bp_next_latency", rec_latency, 3);
        check("bp_next_interval", rec_interval, 7);

        // Reset while ARMED with two outstanding.
        do_reset();
        rec_ready = 1;
        until_cyc(2);
        ap_start = 1; ap_ready = 1;
        step(2);
        ap_ready = 0;
        step(2);
        check("armed_outstanding", outstanding, 2);
        reset = 1;
        step(1);
        ap_start = 0;
        check_reset_vals("midrst");
        reset = 0;
        until_cyc(3);
        ap_start = 1; ap_ready = 1;
        step(1);
        ap_start = 0; ap_ready = 0;
        until_cyc(6);
        ap_done = 1;
        step(1);
        ap_done = 0;
        check("post_rst_id", rec_id, 0);
        check("post_rst_latency", rec_latency, 4);

        // Finish with an attempted start: the start is ignored and flush_done pulses once.
        step(1);
        finish = 1; ap_start = 1; ap_ready = 1;
        step(1);
        finish = 0; ap_start = 0; ap_ready = 0;
        check("flush_pulse", flush_done, 1);
        check("flush_outstanding", outstanding, 0);
        step(1);
        check("flush_single", flush_done, 0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
